// File: rtl/dot_product.sv
// dot_product: pipelined signed dot-product engine.
// Each accepted beat carries one row of A and one row of B-transpose. The
// lane products are registered (stage M), reduced by a registered pairwise
// adder tree (one stage per level), then converted to OUTPUT_WIDTH in a final
// register stage R. Every stage carries a valid bit and the caller's tag.
// A single global advance signal stalls every stage together, so results
// leave in acceptance order with no drops and no duplicates.
//
// Build option: define DOT_PRODUCT_SATURATE_EN to clamp the result when
// OUTPUT_WIDTH is narrower than the exact sum. Without it the low bits are
// kept (wrap-around). Latency is the same in both builds.
//
// INPUT_FEATURES must equal 2**LOG_INPUT_FEATURES, and LOG_INPUT_FEATURES
// must be at least 1.
module dot_product #(
  parameter int INPUT_FEATURES     = 4,
  parameter int LOG_INPUT_FEATURES = 2,
  parameter int INPUT_WIDTH        = 4,
  parameter int WEIGHT_WIDTH       = 8,
  parameter int OUTPUT_WIDTH       = 16,
  parameter int TAG_WIDTH          = 6
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   in_valid,
  output logic                                   in_ready,
  input  logic [INPUT_FEATURES*INPUT_WIDTH-1:0]  inputData,
  input  logic [INPUT_FEATURES*WEIGHT_WIDTH-1:0] weightData,
  input  logic [TAG_WIDTH-1:0]                   in_tag,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic [OUTPUT_WIDTH-1:0]                out_data,
  output logic [TAG_WIDTH-1:0]                   out_tag
);

  // Product width and exact full-sum width.
  localparam int P    = INPUT_WIDTH + WEIGHT_WIDTH;
  localparam int S    = P + LOG_INPUT_FEATURES;
  // Number of data-carrying levels before stage R: M plus one per tree level.
  localparam int NLVL = LOG_INPUT_FEATURES + 1;

  // All tree levels are packed into one flat vector. Level l holds
  // INPUT_FEATURES>>l lanes of P+l bits each; this returns where level l starts.
  function automatic int lvl_off(input int lvl);
    int acc;
    acc = 0;
    for (int j = 0; j < lvl; j++) begin
      acc = acc + (INPUT_FEATURES >> j) * (P + j);
    end
    return acc;
  endfunction

  localparam int TREE_BITS = lvl_off(NLVL);
  localparam int SUM_OFF   = lvl_off(LOG_INPUT_FEATURES);

  // Pipeline state: data for every level, plus per-level valid and tag.
  logic [TREE_BITS-1:0]                tree_q;
  logic [TREE_BITS-1:0]                tree_d;
  logic [NLVL-1:0]                     vld_q;
  logic [NLVL-1:0]                     vld_d;
  logic [NLVL-1:0][TAG_WIDTH-1:0]      tag_q;
  logic [NLVL-1:0][TAG_WIDTH-1:0]      tag_d;

  // Stage R (output register).
  logic                                out_valid_q;
  logic [OUTPUT_WIDTH-1:0]             out_data_q;
  logic [OUTPUT_WIDTH-1:0]             out_data_d;
  logic [TAG_WIDTH-1:0]                out_tag_q;

  // Flow control: the whole pipe moves when the output slot is free or
  // being drained this cycle. Nothing is accepted while reset is held.
  logic advance;
  logic accept;

  assign advance  = !out_valid_q || out_ready;
  assign in_ready = advance && rst;
  assign accept   = in_valid && in_ready;

  genvar gi, gk;

  // Stage M inputs: one signed product per lane. Non-accepted cycles load
  // zeros so that bubbles carry clean data down the pipe.
  generate
    for (gi = 0; gi < INPUT_FEATURES; gi++) begin : g_mul
      logic signed [INPUT_WIDTH-1:0]  a_lane;
      logic signed [WEIGHT_WIDTH-1:0] b_lane;
      logic signed [P-1:0]            prod;

      assign a_lane = inputData[gi*INPUT_WIDTH +: INPUT_WIDTH];
      assign b_lane = weightData[gi*WEIGHT_WIDTH +: WEIGHT_WIDTH];
      assign prod   = a_lane * b_lane;
      assign tree_d[gi*P +: P] = accept ? prod : '0;
    end
  endgenerate

  // Tree levels: lane k of level l is lane 2k + lane 2k+1 of level l-1,
  // each operand sign-extended by one bit so the add is exact.
  generate
    for (gi = 1; gi < NLVL; gi++) begin : g_lvl
      localparam int W     = P + gi;
      localparam int LANES = INPUT_FEATURES >> gi;
      localparam int SRC   = lvl_off(gi - 1);
      localparam int DST   = lvl_off(gi);

      for (gk = 0; gk < LANES; gk++) begin : g_add
        logic [W-2:0] lhs;
        logic [W-2:0] rhs;

        assign lhs = tree_q[SRC + (2*gk)*(W-1) +: W-1];
        assign rhs = tree_q[SRC + (2*gk+1)*(W-1) +: W-1];
        assign tree_d[DST + gk*W +: W] = {lhs[W-2], lhs} + {rhs[W-2], rhs};
      end
    end
  endgenerate

  // Valid and tag shift alongside the data, one entry per level.
  assign vld_d    = {vld_q[NLVL-2:0], accept};
  assign tag_d[0] = accept ? in_tag : '0;

  generate
    for (gi = 1; gi < NLVL; gi++) begin : g_tag
      assign tag_d[gi] = tag_q[gi-1];
    end
  endgenerate

  // Output conversion of the exact sum held in the last tree level.
  logic signed [S-1:0] full_sum;

  assign full_sum = tree_q[SUM_OFF +: S];

  generate
    if (OUTPUT_WIDTH > S) begin : g_sext
      assign out_data_d = {{(OUTPUT_WIDTH-S){full_sum[S-1]}}, full_sum};
    end else if (OUTPUT_WIDTH == S) begin : g_same
      assign out_data_d = full_sum;
    end else begin : g_narrow
`ifdef DOT_PRODUCT_SATURATE_EN
      localparam logic [S-1:0] MAX_S =
        {{(S-OUTPUT_WIDTH+1){1'b0}}, {(OUTPUT_WIDTH-1){1'b1}}};
      localparam logic [S-1:0] MIN_S =
        {{(S-OUTPUT_WIDTH+1){1'b1}}, {(OUTPUT_WIDTH-1){1'b0}}};

      // Clamp to the signed range of OUTPUT_WIDTH.
      always_comb begin
        out_data_d = full_sum[OUTPUT_WIDTH-1:0];
        if (full_sum > $signed(MAX_S)) begin
          out_data_d = {1'b0, {(OUTPUT_WIDTH-1){1'b1}}};
        end else if (full_sum < $signed(MIN_S)) begin
          out_data_d = {1'b1, {(OUTPUT_WIDTH-1){1'b0}}};
        end
      end
`else
      // Wrap-around keeps only the low bits; the discarded high bits are
      // gathered here so their intentional non-use is explicit.
      logic unused_hi_bits;

      assign unused_hi_bits = ^full_sum[S-1:OUTPUT_WIDTH];
      assign out_data_d     = full_sum[OUTPUT_WIDTH-1:0];
`endif
    end
  endgenerate

  // Shift stage M and the tree levels together; reset clears data as well
  // as valid so no unknowns ever reach the output.
  always_ff @(posedge clk) begin
    if (!rst) begin
      tree_q <= '0;
      vld_q  <= '0;
      tag_q  <= '0;
    end else if (advance) begin
      tree_q <= tree_d;
      vld_q  <= vld_d;
      tag_q  <= tag_d;
    end
  end

  // Stage R: capture the converted result; holds while the consumer stalls.
  always_ff @(posedge clk) begin
    if (!rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_tag_q   <= '0;
    end else if (advance) begin
      out_valid_q <= vld_q[NLVL-1];
      out_data_q  <= out_data_d;
      out_tag_q   <= tag_q[NLVL-1];
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_tag   = out_tag_q;

endmodule

// File: tb/tb_dot_product.sv
// tb_dot_product: self-checking bench for dot_product.
// Two instances share the stimulus: the default 16-bit output build and a
// 12-bit output build where the exact 14-bit sum can overflow (clamped when
// DOT_PRODUCT_SATURATE_EN is defined, wrapped otherwise). A queue-based
// scoreboard, filled from an integer reference model at every accept,
// checks every retired result for value, tag and order.
`timescale 1ns/1ps
module tb_dot_product;

  localparam int N  = 4;
  localparam int IW = 4;
  localparam int WW = 8;
  localparam int TW = 6;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              in_valid = 1'b0;
  logic              out_ready = 1'b1;
  logic [N*IW-1:0]   inputData = '0;
  logic [N*WW-1:0]   weightData = '0;
  logic [TW-1:0]     in_tag = '0;

  logic              in_ready;
  logic              out_valid;
  logic [15:0]       out_data;
  logic [TW-1:0]     out_tag;

  logic              in_ready12;
  logic              out_valid12;
  logic [11:0]       out_data12;
  logic [TW-1:0]     out_tag12;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [15:0]   d16;
    logic [11:0]   d12;
    logic [TW-1:0] tag;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   mon_s;

  always #5 clk = ~clk;

  dot_product dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .inputData  (inputData),
    .weightData (weightData),
    .in_tag     (in_tag),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_tag    (out_tag)
  );

  dot_product #(.OUTPUT_WIDTH(12)) dut12 (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready12),
    .inputData  (inputData),
    .weightData (weightData),
    .in_tag     (in_tag),
    .out_valid  (out_valid12),
    .out_ready  (out_ready),
    .out_data   (out_data12),
    .out_tag    (out_tag12)
  );

  task automatic check_eq(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference: plain integer dot product of the sign-interpreted lanes.
  function automatic int ref_sum(input logic [N*IW-1:0] a, input logic [N*WW-1:0] b);
    int s;
    s = 0;
    for (int i = 0; i < N; i++) begin
      s += int'($signed(a[i*IW +: IW])) * int'($signed(b[i*WW +: WW]));
    end
    return s;
  endfunction

  function automatic logic [11:0] conv12(input int s);
`ifdef DOT_PRODUCT_SATURATE_EN
    if (s > 2047) return 12'h7FF;
    if (s < -2048) return 12'h800;
`endif
    return s[11:0];
  endfunction

  // Scoreboard: evaluated mid-cycle, so it sees exactly what the next
  // rising edge will accept and retire.
  always @(negedge clk) begin
    if (!rst) begin
      sb.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check_eq("pending_results", 32'(sb.size()), 32'd1);
        end else begin
          mon_e = sb.pop_front();
          check_eq("out_data", 32'(out_data), 32'(mon_e.d16));
          check_eq("out_tag", 32'(out_tag), 32'(mon_e.tag));
          check_eq("out_valid12", 32'(out_valid12), 32'd1);
          check_eq("out_data12", 32'(out_data12), 32'(mon_e.d12));
          check_eq("out_tag12", 32'(out_tag12), 32'(mon_e.tag));
          $display("result tag=%0d data=0x%04h data12=0x%03h", out_tag, out_data, out_data12);
        end
      end
      if (in_valid && in_ready) begin
        mon_s     = ref_sum(inputData, weightData);
        mon_e.d16 = mon_s[15:0];
        mon_e.d12 = conv12(mon_s);
        mon_e.tag = in_tag;
        sb.push_back(mon_e);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_beat(input int a0, input int a1, input int a2, input int a3,
                          input int b0, input int b1, input int b2, input int b3,
                          input int tag);
    inputData  = {4'(a3), 4'(a2), 4'(a1), 4'(a0)};
    weightData = {8'(b3), 8'(b2), 8'(b1), 8'(b0)};
    in_tag     = TW'(tag);
    in_valid   = 1'b1;
  endtask

  // Stimulus for the extremes test.
  int ext_a[3] = '{-8, 7, 0};
  int ext_16[3] = '{32'h1000, 32'hF200, 32'h0012};
`ifdef DOT_PRODUCT_SATURATE_EN
  int ext_12[3] = '{32'h7FF, 32'h800, 32'h012};
`else
  int ext_12[3] = '{32'h000, 32'h200, 32'h012};
`endif

  // Backpressure test state.
  logic [N*IW-1:0] bp_a[8];
  logic [N*WW-1:0] bp_b[8];
  logic [15:0]     bp_e[8];
  int bp_sent, bp_got, bp_stall, bp_c;
  logic bp_acc, bp_fire;

  logic [5:0] pat;
  int pat_exp;

  initial begin
    // Reset behaviour.
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    cyc(); cyc();
    check_eq("rst_in_ready", 32'(in_ready), 32'd0);
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_out_data", 32'(out_data), 32'd0);
    check_eq("rst_out_tag", 32'(out_tag), 32'd0);
    rst = 1'b1;
    #1;
    check_eq("first_in_ready", 32'(in_ready), 32'd1);

    // Basic: latency and value.
    set_beat(1, 1, 1, 1, 1, 2, 3, 4, 5);
    for (int c = 1; c <= 4; c++) begin
      cyc();
      in_valid = 1'b0;
      if (c < 4) begin
        check_eq("basic_latency_low", 32'(out_valid), 32'd0);
      end else begin
        check_eq("basic_valid", 32'(out_valid), 32'd1);
        check_eq("basic_data", 32'(out_data), 32'd10);
        check_eq("basic_tag", 32'(out_tag), 32'd5);
      end
    end
    cyc(); cyc();

    // Signs and extremes, back to back, both output widths.
    for (int c = 0; c < 8; c++) begin
      if (c == 0)      set_beat(-8, -8, -8, -8, -128, -128, -128, -128, 1);
      else if (c == 1) set_beat(7, 7, 7, 7, -128, -128, -128, -128, 2);
      else if (c == 2) set_beat(-1, 2, -3, 4, 5, 6, 7, 8, 3);
      else             in_valid = 1'b0;
      if (c >= 4 && c < 7) begin
        check_eq("ext_data16", 32'(out_data), 32'(ext_16[c-4]));
        check_eq("ext_data12", 32'(out_data12), 32'(ext_12[c-4]));
        check_eq("ext_a_lane", 32'(ext_a[c-4]), 32'(ext_a[c-4]) ^ 32'(0));
      end
      cyc();
    end
    cyc(); cyc();

    // Bubbles: valid pattern reappears four cycles later with tags intact.
    pat = 6'b101101;
    for (int c = 0; c < 12; c++) begin
      if (c < 6 && pat[c]) set_beat(int'($urandom), int'($urandom), int'($urandom), int'($urandom),
                                    int'($urandom), int'($urandom), int'($urandom), int'($urandom), 10 + c);
      else in_valid = 1'b0;
      pat_exp = (c >= 4 && c < 10) ? int'(pat[c-4]) : 0;
      check_eq("bubble_valid", 32'(out_valid), 32'(pat_exp));
      if (pat_exp == 1) check_eq("bubble_tag", 32'(out_tag), 32'(10 + c - 4));
      cyc();
    end
    cyc(); cyc();

    // Backpressure: 8 beats, consumer stalls 3 cycles after the 2nd result.
    for (int i = 0; i < 8; i++) begin
      int sv;
      bp_a[i] = N*IW'($urandom);
      bp_b[i] = $urandom;
      sv = ref_sum(bp_a[i], bp_b[i]);
      bp_e[i] = sv[15:0];
    end
    bp_sent = 0; bp_got = 0; bp_stall = 0; bp_c = 0;
    while (bp_got < 8 && bp_c < 60) begin
      if (bp_sent < 8) begin
        inputData = bp_a[bp_sent]; weightData = bp_b[bp_sent];
        in_tag = TW'(bp_sent); in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      out_ready = (bp_stall == 0);
      #1;
      if (bp_stall > 0) begin
        check_eq("stall_in_ready", 32'(in_ready), 32'd0);
        check_eq("stall_valid", 32'(out_valid), 32'd1);
        check_eq("stall_tag", 32'(out_tag), 32'd2);
        check_eq("stall_data", 32'(out_data), 32'(bp_e[2]));
      end
      bp_acc  = in_valid && in_ready;
      bp_fire = out_valid && out_ready;
      cyc();
      bp_c++;
      if (bp_acc) bp_sent++;
      if (bp_fire) begin
        bp_got++;
        if (bp_got == 2) bp_stall = 3;
      end else if (bp_stall > 0) begin
        bp_stall--;
      end
    end
    check_eq("bp_results", 32'(bp_got), 32'd8);
    out_ready = 1'b1;
    in_valid = 1'b0;
    cyc(); cyc();

    // Reset mid-stream: three beats in flight are discarded.
    for (int c = 0; c < 3; c++) begin
      set_beat(3, 3, 3, 3, 9, 9, 9, 9, 20 + c);
      cyc();
    end
    in_valid = 1'b0;
    rst = 1'b0;
    cyc();
    rst = 1'b1;
    check_eq("midrst_valid", 32'(out_valid), 32'd0);
    check_eq("midrst_data", 32'(out_data), 32'd0);
    check_eq("midrst_tag", 32'(out_tag), 32'd0);
    for (int c = 0; c < 8; c++) begin
      check_eq("midrst_flushed", 32'(out_valid), 32'd0);
      cyc();
    end

    // Reset mid-stall: a held result is discarded as well.
    out_ready = 1'b0;
    set_beat(7, 7, 7, 7, 1, 1, 1, 1, 30);
    cyc();
    in_valid = 1'b0;
    for (int c = 0; c < 10 && !out_valid; c++) cyc();
    check_eq("stallrst_held", 32'(out_valid), 32'd1);
    check_eq("stallrst_held_data", 32'(out_data), 32'd28);
    rst = 1'b0;
    cyc();
    rst = 1'b1;
    check_eq("stallrst_valid", 32'(out_valid), 32'd0);
    check_eq("stallrst_data", 32'(out_data), 32'd0);
    check_eq("stallrst_tag", 32'(out_tag), 32'd0);
    out_ready = 1'b1;

    // Fresh beat after reset.
    set_beat(1, -2, 3, -4, 5, 6, 7, 8, 33);
    for (int c = 1; c <= 4; c++) begin
      cyc();
      in_valid = 1'b0;
      if (c == 4) begin
        check_eq("fresh_valid", 32'(out_valid), 32'd1);
        check_eq("fresh_data", 32'(out_data), 32'h0000FFEE);
        check_eq("fresh_tag", 32'(out_tag), 32'd33);
      end
    end
    cyc(); cyc();

    // Randomized traffic with random backpressure.
    for (int c = 0; c < 400; c++) begin
      in_valid   = ($urandom_range(0, 3) != 0);
      inputData  = N*IW'($urandom);
      weightData = $urandom;
      in_tag     = TW'($urandom);
      if ($urandom_range(0, 9) == 0) begin
        inputData  = 16'h8888;
        weightData = 32'h80808080;
      end else if ($urandom_range(0, 9) == 0) begin
        inputData  = 16'h7777;
        weightData = 32'h80808080;
      end
      out_ready = ($urandom_range(0, 3) != 0);
      cyc();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 20 && sb.size() != 0; c++) cyc();
    check_eq("drain_empty", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/dot_product.md
# dot_product

Pipelined signed dot-product engine sitting directly downstream of `matrix_mult`'s row sequencer. Each accepted beat carries one row of A (`inputData`) and one row of Bᵀ (`weightData`). It multiplies the INPUT_FEATURES lane pairs, reduces them through a registered adder tree and emits one element of C with its caller-supplied tag. Throughput is one vector per cycle, with ready/valid backpressure on both sides.

## Interface
- INPUT_FEATURES, 4, lanes per vector (N); must equal 2**LOG_INPUT_FEATURES
- LOG_INPUT_FEATURES, 2, adder-tree depth
- INPUT_WIDTH, 4, signed bits per A element
- WEIGHT_WIDTH, 8, signed bits per B element
- OUTPUT_WIDTH, 16, signed bits of result
- TAG_WIDTH, 6, opaque sideband (row/column index) carried alongside each vector
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-low reset
- in_valid  in  1  input beat valid
- in_ready  out  1  block accepts beat this cycle
- inputData  in  INPUT_FEATURES*INPUT_WIDTH  A row; lane i at [i*INPUT_WIDTH +: INPUT_WIDTH], lane 0 at LSB
- weightData  in  INPUT_FEATURES*WEIGHT_WIDTH  Bᵀ row; same lane packing
- in_tag  in  TAG_WIDTH  sideband for this beat
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_data  out  OUTPUT_WIDTH  signed dot product
- out_tag  out  TAG_WIDTH  in_tag of the producing beat

## Operation
- Widths: product P = INPUT_WIDTH+WEIGHT_WIDTH; full sum S = P+LOG_INPUT_FEATURES. All arithmetic is signed two's complement. The full sum is exact; no overflow is possible inside the tree.
- Pipeline stages:
  - Stage M registers the N products.
  - Stages T1..T(LOG_INPUT_FEATURES) each halve the lane count with pairwise adds (lane 2k + lane 2k+1), widening by 1 bit per stage.
  - Stage R registers the output conversion.
- Every stage carries a valid bit and the tag.
- Output conversion:
  - OUTPUT_WIDTH ≥ S: sign-extend.
  - OUTPUT_WIDTH < S: see Configuration.
- Advance rule: `advance = !out_valid || out_ready`. When advance is high, all stages shift by one. When it is low, all stage registers (data, valid, tag) hold.
- `in_ready = advance && rst`, combinational. A beat is accepted when `in_valid && in_ready`.
- Empty slots: a cycle with advance high and no accepted beat inserts a bubble (valid 0). Bubbles are not compressed.
- Ordering: results leave in acceptance order, one result per accepted beat. No drops, no duplicates.
- Inputs are sampled only on an accepting edge. inputData/weightData may change freely otherwise.

## Timing
- Latency L = LOG_INPUT_FEATURES + 2 cycles, from the accepting edge to the edge where out_valid rises (default 4), with out_ready held high.
- Sustained throughput is 1 result/cycle with in_valid and out_ready both held high.
- Stall:
  - While out_valid=1 and out_ready=0, out_data and out_tag are stable and in_ready=0.
  - Recovery: the cycle out_ready returns high, that result retires and one new beat may be accepted in the same cycle.
- Reset (rst=0 at a rising edge):
  - All stage valid bits clear; out_valid=0, out_data=0, out_tag=0.
  - in_ready=0 while rst is low.
  - In-flight data is discarded, including when reset asserts mid-stream or mid-stall.
  - The first accept is possible in the first cycle after rst returns high.
- No X propagation: data and tag registers reset to 0 as well as the valid bits.

## Configuration
- `DOT_PRODUCT_SATURATE_EN` defined: when OUTPUT_WIDTH < S, the result clamps to [−2^(OUTPUT_WIDTH−1), 2^(OUTPUT_WIDTH−1)−1].
- `DOT_PRODUCT_SATURATE_EN` undefined: when OUTPUT_WIDTH < S, the result is the low OUTPUT_WIDTH bits of the full sum (wrap-around).
- When OUTPUT_WIDTH ≥ S the macro has no effect. Latency is identical in both builds.

## Test plan
- Basic: defaults; A lanes {1,1,1,1}, B lanes {1,2,3,4}, tag 5, out_ready=1 -> out_valid exactly 4 cycles later, out_data=10, out_tag=5.
- Signs/extremes: A lanes all −8, B lanes all −128 -> 4096. A lanes all 7, B lanes all −128 -> −3584 (0xF200). A lanes {−1,2,−3,4}, B lanes {5,6,7,8} -> 18.
- Overflow, OUTPUT_WIDTH=12 (S=14), A all −8, B all −128 (sum 4096):
  - with `DOT_PRODUCT_SATURATE_EN` -> 2047 (0x7FF)
  - without -> 0x000
  - A all 7, B all −128 (sum −3584): −2048 (0x800) saturated, 0x200 wrapped.
- Backpressure: stream 8 beats, tags 0–7, back-to-back; drop out_ready for 3 cycles after the 2nd result -> in_ready low during the stall, out_data/out_tag frozen, all 8 results delivered in tag order 0–7 with correct values, no duplicates.
- Bubbles: in_valid pattern 1,0,1,1,0,1 -> out_valid shows the same pattern delayed by 4 cycles, with tags preserved.
- Reset mid-operation: 3 beats in flight, rst=0 for 1 cycle -> out_valid=0, out_data=0, out_tag=0 the next cycle. None of the 3 results ever appears. A fresh beat accepted after release returns the correct result after 4 cycles.
